operand_entry: RTL and testbench

Sequential front end for the 4-bit adder/subtractor datapath. It collects two 4-bit operands and an add/subtract select from one switch bank and a single push-button, one entry per press, then holds them stable on its outputs. Those outputs drive the adder/subtractor directly, so the arithmetic stage always sees clean, registered operands instead of live switches. It sits between the board I/O (switches, key) and the arithmetic stage.

---
 rtl/operand_entry_pkg.sv | 17 +
 rtl/operand_entry_if.sv | 34 +++
 rtl/operand_entry_debounce.sv | 73 +++++++
 rtl/operand_entry.sv | 99 +++++++++
 tb/tb_operand_entry.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry front end.
// Contents: FSM state encoding (also driven onto the phase LEDs) and the
// add/subtract select codes used by the downstream arithmetic stage.
package operand_entry_pkg;

    // Encoding doubles as the LED phase code; 2'b11 is unused and recovers
    // to ST_LOAD_A on the next edge.
    typedef enum logic [1:0] {
        ST_LOAD_A = 2'b00,
        ST_LOAD_B = 2'b01,
        ST_READY  = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/operand_entry_if.sv
// Bundle between the board I/O side and the operand entry block.
// Signals:
//   sw, op_sw, enter, clear  board side -> entry block (raw switches/key)
//   a0, a1, s                registered operands and add/subtract select
//   operands_valid           level, high only while phase == READY
//   phase                    FSM state code for the LEDs
// Handshake: there is no ready back-pressure. operands_valid is a plain
// level qualifier: while it is high a0/a1/s are stable and complete; the
// consumer may sample them on any cycle it sees operands_valid high.
interface operand_entry_if
    import operand_entry_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic             op_sw;
    logic             enter;
    logic             clear;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic             s;
    logic             operands_valid;
    logic [1:0]       phase;

    modport master (
        output sw, op_sw, enter, clear,
        input  a0, a1, s, operands_valid, phase
    );

    modport slave (
        input  sw, op_sw, enter, clear,
        output a0, a1, s, operands_valid, phase
    );
endinterface

// File: rtl/operand_entry_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle rising-edge pulse.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   raw    raw, bouncy, asynchronous key level (active-high)
//   press  one-cycle pulse per accepted press
// A key held through reset is not reported: the pulse is only produced
// once the key has been seen released (debounced fall, or the
// synchronized level low for DEBOUNCE_CYCLES cycles). That idle window
// must exceed the two reset-zero synchronizer samples, so use
// DEBOUNCE_CYCLES >= 3.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            armed    <= 1'b0;
            cnt      <= '0;
            idle_cnt <= '0;
            press    <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;

            // Counter only runs while the synchronized input disagrees
            // with the accepted level; any agreement restarts it.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
                if (level) begin
                    armed <= 1'b1;  // accepted release
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Arms after reset once the key is genuinely idle.
            if (armed || sync2 || level) begin
                idle_cnt <= '0;
            end else if (idle_cnt == LAST) begin
                armed <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            press <= level & ~level_d & armed;
        end
    end
endmodule

// File: rtl/operand_entry.sv
// Operand entry front end: collects operand A, operand B and the
// add/subtract select, one entry per key press, and holds them stable.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (also resets the key conditioner)
//   bus   operand_entry_if.slave: raw switches/key/clear in, registered
//         operands, select, valid flag and phase code out
// clear returns to operand-A entry and zeroes the operands but leaves the
// switch synchronizers and key conditioner running.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic               clk,
    input logic               rst,
    operand_entry_if.slave    bus
);
    logic [WIDTH-1:0] sw_s1;
    logic [WIDTH-1:0] sw_s2;
    logic             op_s1;
    logic             op_s2;
    logic             press;

    state_t           state;
    logic [WIDTH-1:0] a0_q;
    logic [WIDTH-1:0] a1_q;
    logic             s_q;
    logic             valid_q;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.enter),
        .press (press)
    );

    // Switches are only sampled on press, so synchronizing is enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            op_s1 <= 1'b0;
            op_s2 <= 1'b0;
        end else begin
            sw_s1 <= bus.sw;
            sw_s2 <= sw_s1;
            op_s1 <= bus.op_sw;
            op_s2 <= op_s1;
        end
    end

    // clear outranks press: a press landing on the clear cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state   <= ST_LOAD_A;
            a0_q    <= '0;
            a1_q    <= '0;
            s_q     <= OP_ADD;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_A: begin
                    if (press) begin
                        a0_q  <= sw_s2;
                        state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (press) begin
                        a1_q    <= sw_s2;
                        s_q     <= op_s2;
                        state   <= ST_READY;
                        valid_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (press) begin
                        state   <= ST_LOAD_A;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_LOAD_A;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a0             = a0_q;
    assign bus.a1             = a1_q;
    assign bus.s              = s_q;
    assign bus.operands_valid = valid_q;
    assign bus.phase          = state;
endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with a 4-cycle debounce window. A reference
// model of the entry sequence (phase counter and operand variables)
// pushes the expected packed outputs {valid, phase, s, a1, a0} into
// exp_q; every observation pops one and compares it.
module tb_operand_entry;
    import operand_entry_pkg::*;

    localparam int W  = 4;
    localparam int DB = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    operand_entry_if #(.WIDTH(W)) bus ();

    operand_entry #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // reference model
    int             m_phase;
    logic [W-1:0]   m_a0;
    logic [W-1:0]   m_a1;
    logic           m_s;
    logic [11:0]    exp_q[$];

    task automatic model_press(input logic [W-1:0] sw_v, input logic op_v);
        if (m_phase == 0) begin
            m_a0    = sw_v;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_a1    = sw_v;
            m_s     = op_v;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_a0    = '0;
        m_a1    = '0;
        m_s     = 1'b0;
    endtask

    task automatic expect_now();
        logic [1:0] ph;
        ph = 2'(m_phase);
        exp_q.push_back({(m_phase == 2), ph, m_s, m_a1, m_a0});
    endtask

    // checker
    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_dut(input string tag);
        logic [11:0] e;
        e = exp_q.pop_front();
        check_eq(tag, {bus.operands_valid, bus.phase, bus.s, bus.a1, bus.a0}, e);
    endtask

    // drivers (inputs change 1 time unit after a rising edge)
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_press(input logic [W-1:0] sw_v, input logic op_v,
                            input int hold, input int rel, input string tag);
        bus.sw    = sw_v;
        bus.op_sw = op_v;
        bus.enter = 1'b1;
        tick(hold);
        bus.enter = 1'b0;
        tick(rel);
        model_press(sw_v, op_v);
        expect_now();
        compare_dut(tag);
    endtask

    task automatic do_clear(input string tag);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        tick(1);
        model_clear();
        expect_now();
        compare_dut(tag);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        bus.sw    = '0;
        bus.op_sw = 1'b0;
        bus.enter = 1'b0;
        bus.clear = 1'b0;
        model_clear();

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        expect_now();
        compare_dut("reset_idle");

        // A = 5, then B = 3 subtract with exact latency on operands_valid
        do_press(4'h5, OP_ADD, 10, 12, "load_a");
        bus.sw    = 4'h3;
        bus.op_sw = OP_SUB;
        bus.enter = 1'b1;
        tick(7);
        check_eq("valid_at_7", {11'b0, bus.operands_valid}, 12'h000);
        tick(1);
        check_eq("valid_at_8", {11'b0, bus.operands_valid}, 12'h001);
        tick(5);
        bus.enter = 1'b0;
        tick(12);
        model_press(4'h3, OP_SUB);
        expect_now();
        compare_dut("load_b_ready");

        // bouncy press from READY: exactly one advance
        for (int i = 0; i < 12; i++) begin
            bus.enter = ((i / 2) % 2 == 0);
            tick(1);
        end
        bus.enter = 1'b1;
        tick(10);
        bus.enter = 1'b0;
        tick(12);
        model_press(4'h0, OP_ADD);
        expect_now();
        compare_dut("bounce_one_step");

        // held 100 cycles in LOAD_A, switches move mid-hold
        bus.sw    = 4'h9;
        bus.enter = 1'b1;
        tick(20);
        bus.sw = 4'hE;
        tick(80);
        model_press(4'h9, OP_ADD);
        expect_now();
        compare_dut("hold_100");
        bus.enter = 1'b0;
        tick(12);
        expect_now();
        compare_dut("hold_release");

        // reach READY, then clear coinciding with the press pulse
        do_press(4'h6, OP_SUB, 10, 12, "to_ready");
        bus.sw    = 4'h2;
        bus.enter = 1'b1;
        tick(7);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        tick(5);
        bus.enter = 1'b0;
        tick(12);
        model_clear();
        expect_now();
        compare_dut("clear_vs_press");

        // randomized press / clear sequence
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 4) begin
                do_clear("rand_clear");
            end else begin
                do_press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         $urandom_range(8, 30), $urandom_range(10, 20), "rand_press");
            end
        end

        // reset mid-debounce with the key held
        do_clear("pre_rst_clear");
        do_press(4'hA, OP_ADD, 10, 12, "pre_rst_load");
        bus.enter = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(30);
        model_clear();
        expect_now();
        compare_dut("rst_held");
        bus.enter = 1'b0;
        tick(10);
        expect_now();
        compare_dut("rst_released");
        do_press(4'h7, OP_SUB, 10, 12, "repress");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
